record_packer: RTL and testbench

- Consumer end of the event tagger record stream.
- Captures each 47-bit timestamp record presented with `data_rdy` into a small FIFO.
- Serializes each record as six bytes onto an 8-bit valid/ready stream toward the host interface.
- Counts and flags records dropped while the FIFO is full, so host software can detect gaps.

---
 rtl/tagger_pkg.sv | 9 +
 rtl/record_packer_if.sv | 9 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/record_packer.sv | 107 ++++++++++
 tb/tb_record_packer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tagger_pkg.sv
// rtl/tagger_pkg.sv - shared widths, lost-flag position and serializer states
package tagger_pkg;
  localparam int REC_WIDTH  = 47;
  localparam int WORD_WIDTH = 48;
  localparam int REC_BYTES  = 6;
  localparam int LOST_BIT   = 47;

  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/record_packer_if.sv
// rtl/record_packer_if.sv - byte stream toward the host interface
interface record_packer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with head data visible combinationally
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // full is judged on the start-of-cycle count, so a same-cycle pop never frees a slot
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/record_packer.sv
// rtl/record_packer.sv - buffers tagger records and serializes them LSB-first as bytes
module record_packer
  import tagger_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int LOST_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     data_rdy,
  input  logic [REC_WIDTH-1:0]     data,
  record_packer_if.master          host,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [LOST_WIDTH-1:0]    lost_count
);
  state_t                state;
  logic [WORD_WIDTH-1:0] head;
  logic [WORD_WIDTH-1:0] shift;
  logic [2:0]            byte_idx;
  logic                  valid_q;
  logic                  lost_pending;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  last_byte;
  logic                  pop;

  assign last_byte = (byte_idx == 3'(REC_BYTES - 1));
  assign pop = ~clear & ~fifo_empty &
               ((state == IDLE) | ((state == SEND) & host.out_ready & last_byte));

  assign host.out_data  = shift[7:0];
  assign host.out_valid = valid_q;

  sync_fifo #(.WIDTH(WORD_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (data_rdy),
    .pop   (pop),
    .wdata ({lost_pending, data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // lost_pending tags the next stored record so the host can see the gap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lost_pending <= 1'b0;
      lost_count   <= '0;
    end else if (clear) begin
      lost_pending <= 1'b0;
      lost_count   <= '0;
    end else if (data_rdy) begin
      if (fifo_full) begin
        lost_pending <= 1'b1;
        if (~&lost_count) lost_count <= lost_count + 1'b1;
      end else begin
        lost_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      byte_idx <= '0;
      valid_q  <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      byte_idx <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shift    <= head;
            byte_idx <= '0;
            valid_q  <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (host.out_ready) begin
            if (last_byte) begin
              // reload in the same edge to keep the stream gap-free
              if (!fifo_empty) begin
                shift    <= head;
                byte_idx <= '0;
              end else begin
                valid_q <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              shift    <= shift >> 8;
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_record_packer.sv
// tb/tb_record_packer.sv - directed and random checks of record_packer against a queue model
module tb_record_packer;
  localparam int DEPTH  = 16;
  localparam int DEPTH2 = 2;
  localparam int LMAX   = 65535;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        data_rdy;
  logic [46:0] data;
  logic [4:0]  fifo_count;
  logic [15:0] lost_count;
  logic [1:0]  fifo_count2;
  logic [1:0]  lost_count2;

  record_packer_if bus();
  record_packer_if bus2();

  record_packer #(.DEPTH(DEPTH), .LOST_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .clear(clear), .data_rdy(data_rdy), .data(data),
    .host(bus), .fifo_count(fifo_count), .lost_count(lost_count)
  );

  record_packer #(.DEPTH(DEPTH2), .LOST_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .data_rdy(data_rdy), .data(data),
    .host(bus2), .fifo_count(fifo_count2), .lost_count(lost_count2)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference: stored words, the word on the wire and the byte position within it
  logic [47:0] mq[$];
  logic [47:0] m_cur;
  bit          m_send;
  int          m_idx;
  bit          m_pend;
  int          m_lost;
  logic [7:0]  got[$];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_send = 0;
    m_idx  = 0;
    m_pend = 0;
    m_lost = 0;
  endtask

  task automatic model_edge();
    bit full;
    if (reset || clear) begin
      model_reset();
      return;
    end
    full = (mq.size() == DEPTH);
    if (!m_send) begin
      if (mq.size() > 0) begin
        m_cur  = mq.pop_front();
        m_idx  = 0;
        m_send = 1;
      end
    end else if (bus.out_ready) begin
      if (m_idx == 5) begin
        if (mq.size() > 0) begin
          m_cur = mq.pop_front();
          m_idx = 0;
        end else begin
          m_send = 0;
        end
      end else begin
        m_idx++;
      end
    end
    if (data_rdy) begin
      if (!full) begin
        mq.push_back({m_pend, data});
        m_pend = 0;
      end else begin
        m_pend = 1;
        if (m_lost < LMAX) m_lost++;
      end
    end
  endtask

  task automatic step();
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) got.push_back(bus.out_data);
    @(posedge clk);
    model_edge();
    #1;
    check("valid", bus.out_valid, m_send);
    if (m_send) check("data", bus.out_data, m_cur[8*m_idx +: 8]);
    check("fifo_count", fifo_count, mq.size());
    check("lost_count", lost_count, m_lost);
  endtask

  task automatic strobe(logic [46:0] d);
    data = d;
    data_rdy = 1'b1;
    step();
    data_rdy = 1'b0;
  endtask

  logic [7:0] hold_byte;
  bit         hold_armed;
  int         peak;
  int         first_v;
  int         n_valid;
  int         last_v;

  initial begin
    reset = 1'b1; clear = 1'b0; data_rdy = 1'b0; data = '0; bus.out_ready = 1'b0; bus2.out_ready = 1'b0;
    model_reset();
    step(); step();
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_lost", lost_count, 0);
    reset = 1'b0;
    step();

    // single record and its latency
    bus.out_ready = 1'b1;
    got.delete();
    strobe(47'h1234_5678_9ABC);
    check("lat_after_strobe_edge", bus.out_valid, 0);
    step();
    check("lat_two_cycles", bus.out_valid, 1);
    for (int i = 0; i < 8; i++) step();
    check("single_nbytes", got.size(), 6);
    if (got.size() == 6) begin
      check("single_b0", got[0], 8'hBC); check("single_b1", got[1], 8'h9A);
      check("single_b2", got[2], 8'h78); check("single_b3", got[3], 8'h56);
      check("single_b4", got[4], 8'h34); check("single_b5", got[5], 8'h12);
    end
    check("single_lost", lost_count, 0);

    // backpressure with ready pattern 1,0,0,1
    got.delete();
    hold_armed = 0;
    strobe(47'h1234_5678_9ABC);
    for (int i = 0; i < 32; i++) begin
      bus.out_ready = (i % 4 == 0 || i % 4 == 3);
      if (hold_armed) check("bp_hold", bus.out_data, hold_byte);
      hold_armed = (bus.out_valid === 1'b1 && !bus.out_ready);
      hold_byte  = bus.out_data;
      step();
    end
    check("bp_nbytes", got.size(), 6);
    if (got.size() == 6) begin
      check("bp_b0", got[0], 8'hBC);
      check("bp_b5", got[5], 8'h12);
    end

    // overflow: one record on the wire, DEPTH stored, three dropped
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) strobe(47'({$urandom(), $urandom()}));
    check("ovf_lost", lost_count, 3);
    check("ovf_full", fifo_count, DEPTH);
    got.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < (DEPTH + 1) * 6 + 4; i++) step();
    check("ovf_nbytes", got.size(), (DEPTH + 1) * 6);
    for (int r = 0; r < DEPTH + 1 && r * 6 + 5 < got.size(); r++)
      check("ovf_flag_clear", got[r*6+5][7], 0);
    got.delete();
    strobe(47'h7F00_0000_0001);
    for (int i = 0; i < 8; i++) step();
    check("gap_nbytes", got.size(), 6);
    if (got.size() == 6) check("gap_flag_set", got[5], 8'hFF);
    got.delete();
    strobe(47'h7F00_0000_0002);
    for (int i = 0; i < 8; i++) step();
    if (got.size() == 6) check("gap_flag_cleared", got[5], 8'h7F);
    else check("gap2_nbytes", got.size(), 6);

    // back-to-back records
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_lost", lost_count, 0);
    peak = 0; first_v = -1; n_valid = 0; last_v = -1;
    for (int i = 0; i < 32; i++) begin
      if (i < 4) begin data = 47'({$urandom(), $urandom()}); data_rdy = 1'b1; end
      else data_rdy = 1'b0;
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (bus.out_valid === 1'b1) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        n_valid++;
      end
    end
    check("b2b_peak", peak, 3);
    check("b2b_nvalid", n_valid, 24);
    check("b2b_span", last_v - first_v + 1, 24);

    // clear mid-record, with a strobe in the clear cycle
    got.delete();
    strobe(47'h0ABC_DEF0_1234);
    for (int i = 0; i < 20 && got.size() < 3; i++) step();
    check("clr_pre_bytes", got.size(), 3);
    bus.out_ready = 1'b0;
    clear = 1'b1; data_rdy = 1'b1; data = 47'h1111_2222_3333;
    step();
    clear = 1'b0; data_rdy = 1'b0;
    check("clr_valid", bus.out_valid, 0);
    check("clr_fifo_count", fifo_count, 0);
    check("clr_lost", lost_count, 0);
    step();
    check("clr_strobe_dropped", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    got.delete();
    strobe(47'h0102_0304_0506);
    for (int i = 0; i < 8; i++) step();
    check("clr_fresh_nbytes", got.size(), 6);
    if (got.size() == 6) begin
      check("clr_fresh_b0", got[0], 8'h06);
      check("clr_fresh_b5", got[5], 8'h01);
    end

    // saturation on the narrow-counter instance
    bus.out_ready = 1'b0;
    clear = 1'b1; step(); clear = 1'b0;
    check("sat_start", lost_count2, 0);
    for (int i = 0; i < 4; i++) strobe(47'(i));
    check("sat_one_drop", lost_count2, 1);
    check("sat_full", fifo_count2, 2);
    for (int i = 0; i < 4; i++) strobe(47'(i + 4));
    check("sat_held", lost_count2, 3);

    // random traffic
    clear = 1'b1; step(); clear = 1'b0;
    for (int i = 0; i < 600; i++) begin
      clear         = ($urandom_range(0, 199) == 0);
      data_rdy      = ($urandom_range(0, 2) != 0);
      data          = 47'({$urandom(), $urandom()});
      bus.out_ready = ((i / 60) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    clear = 1'b0; data_rdy = 1'b0;

    // asynchronous reset mid-record
    bus.out_ready = 1'b1;
    clear = 1'b1; step(); clear = 1'b0;
    strobe(47'h0000_0000_00AA);
    step(); step();
    check("arst_pre_valid", bus.out_valid, 1);
    reset = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_fifo_count", fifo_count, 0);
    check("arst_data", bus.out_data, 0);
    model_reset();
    step();
    reset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
